// File: rtl/ifu_rand_victim_sel_pkg.sv
// ----------------------------------------------------------------------------
// ifu_rand_victim_sel_pkg
//
// Purpose:
//   Shared definitions for the I-cache random-replacement victim selector and
//   the small helpers around it.
//
// Contents:
//   victim_sel_state_e : selector FSM states (IDLE, DRAW, HOLD)
//   REJECT_CNT_W       : width of the saturating rejected-draw counter
//   RETRY_CNT_W        : width of the per-miss retry counter
//                        (sized for the largest allowed MAX_RETRY of 15)
// ----------------------------------------------------------------------------
package ifu_rand_victim_sel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } victim_sel_state_e;

  localparam int REJECT_CNT_W = 16;
  localparam int RETRY_CNT_W  = 4;

endpackage : ifu_rand_victim_sel_pkg

// File: rtl/ifu_way_onehot_dec.sv
// ----------------------------------------------------------------------------
// ifu_way_onehot_dec
//
// Purpose:
//   Binary way index to one-hot way vector decoder. It is used by the victim
//   selector and by the fill path. When en_i is low the output is all zeros,
//   so the caller gets a clean "no way selected" value without extra gating.
//
// Ports:
//   idx_i  [IDX_W-1:0]     binary way index
//   en_i                   decode enable
//   way_o  [NUM_WAYS-1:0]  one-hot way (all zeros when disabled)
// ----------------------------------------------------------------------------
module ifu_way_onehot_dec #(
  parameter  int NUM_WAYS = 4,
  localparam int IDX_W    = $clog2(NUM_WAYS)
) (
  input  logic [IDX_W-1:0]    idx_i,
  input  logic                en_i,
  output logic [NUM_WAYS-1:0] way_o
);

  // Compare the index against every way number. Any index value at or above
  // NUM_WAYS decodes to all zeros and never aliases onto a real way.
  always_comb begin
    way_o = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (en_i && (idx_i == IDX_W'(i))) begin
        way_o[i] = 1'b1;
      end
    end
  end

endmodule : ifu_way_onehot_dec

// File: rtl/ifu_rand_victim_sel.sv
// ----------------------------------------------------------------------------
// ifu_rand_victim_sel
//
// Purpose:
//   Random-replacement victim selector for the MBPTA I-cache. It turns the
//   per-cycle value from the IFU LFSR into a uniformly distributed victim way
//   on every I-cache miss.
//   - When NUM_WAYS is not a power of two, it uses rejection sampling.
//   - After MAX_RETRY rejected draws it falls back to a deterministic pick.
//   - It holds the chosen way stable until the fill completes.
//
// Ports:
//   clk           core clock
//   rst           asynchronous active-high reset
//   rnd_i         PRNG output; a new value every cycle
//   miss_req_i    level miss request; held until victim_vld_o is seen
//   way_valid_i   valid bits of the missed set
//   fill_done_i   single-cycle pulse: fill written, victim released
//   flush_i       aborts any selection in progress
//   victim_vld_o  victim outputs are valid and stable (FSM in HOLD)
//   victim_way_o  one-hot victim way (all zeros when not valid)
//   victim_idx_o  binary victim way
//   busy_o        selector is not idle
//   reject_cnt_o  saturating count of rejected draws since reset
// ----------------------------------------------------------------------------
module ifu_rand_victim_sel
  import ifu_rand_victim_sel_pkg::*;
#(
  parameter  int NUM_WAYS      = 4,
  parameter  int RND_W         = 3,
  parameter  int MAX_RETRY     = 7,
  parameter  int INVALID_FIRST = 0,
  localparam int IDX_W         = $clog2(NUM_WAYS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RND_W-1:0]        rnd_i,
  input  logic                    miss_req_i,
  input  logic [NUM_WAYS-1:0]     way_valid_i,
  input  logic                    fill_done_i,
  input  logic                    flush_i,
  output logic                    victim_vld_o,
  output logic [NUM_WAYS-1:0]     victim_way_o,
  output logic [IDX_W-1:0]        victim_idx_o,
  output logic                    busy_o,
  output logic [REJECT_CNT_W-1:0] reject_cnt_o
);

  localparam logic [IDX_W:0]         WAYS_EXT    = (IDX_W + 1)'(NUM_WAYS);
  localparam logic [RETRY_CNT_W-1:0] RETRY_LIMIT = RETRY_CNT_W'(MAX_RETRY);

  victim_sel_state_e         state_q,     state_d;
  logic [RETRY_CNT_W-1:0]    retryCnt_q,  retryCnt_d;
  logic [IDX_W-1:0]          victimIdx_q, victimIdx_d;
  logic [REJECT_CNT_W-1:0]   rejectCnt_q, rejectCnt_d;

  logic [IDX_W-1:0] cand;
  logic [IDX_W:0]   candExt;
  logic             candInRange;
  logic [IDX_W-1:0] candWrapped;
  logic             anyInvalid;
  logic [IDX_W-1:0] lowestInvalid;
  logic             unusedRndBits;

  // The candidate way is taken from the low PRNG bits only. It is widened by
  // one bit so that the range check and the wrap-around subtraction cannot
  // overflow. Because cand < 2*NUM_WAYS always holds, the wrapped value
  // (cand - NUM_WAYS) is always a legal way whenever cand itself is not.
  always_comb begin
    cand        = rnd_i[IDX_W-1:0];
    candExt     = {1'b0, cand};
    candInRange = (candExt < WAYS_EXT);
    candWrapped = IDX_W'(candExt - WAYS_EXT);
  end

  // The upper PRNG bits have no role in selecting a way. This reduction
  // simply marks them as deliberately unused.
  assign unusedRndBits = ^rnd_i;

  // Lowest-index invalid way priority encoder. The loop walks from the top
  // way down, so the last assignment that wins is the lowest invalid index.
  always_comb begin
    anyInvalid    = ~&way_valid_i;
    lowestInvalid = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!way_valid_i[i]) begin
        lowestInvalid = IDX_W'(i);
      end
    end
  end

  // Next-state logic for the selector FSM and its counters.
  // - Flush overrides everything and returns the FSM to a clean IDLE.
  // - In DRAW, an invalid way (when enabled) beats a random pick, and an
  //   in-range random pick beats rejection.
  // - A rejection on the last allowed retry still counts as a rejection,
  //   but it ends the draw with the wrapped candidate so that latency stays
  //   bounded.
  always_comb begin
    state_d     = state_q;
    retryCnt_d  = retryCnt_q;
    victimIdx_d = victimIdx_q;
    rejectCnt_d = rejectCnt_q;

    if (flush_i) begin
      state_d     = IDLE;
      retryCnt_d  = '0;
      victimIdx_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (miss_req_i) begin
            state_d    = DRAW;
            retryCnt_d = '0;
          end
        end

        DRAW: begin
          if ((INVALID_FIRST != 0) && anyInvalid) begin
            victimIdx_d = lowestInvalid;
            state_d     = HOLD;
          end else if (candInRange) begin
            victimIdx_d = cand;
            state_d     = HOLD;
          end else begin
            if (rejectCnt_q != '1) begin
              rejectCnt_d = rejectCnt_q + 1'b1;
            end
            if (retryCnt_q == RETRY_LIMIT) begin
              victimIdx_d = candWrapped;
              state_d     = HOLD;
            end else begin
              retryCnt_d = retryCnt_q + 1'b1;
            end
          end
        end

        HOLD: begin
          // A miss that is still pending here waits one IDLE cycle before
          // it starts a new draw, so two HOLD periods never run back to back.
          if (fill_done_i) begin
            state_d     = IDLE;
            retryCnt_d  = '0;
            victimIdx_d = '0;
          end
        end

        default: begin
          state_d     = IDLE;
          retryCnt_d  = '0;
          victimIdx_d = '0;
        end
      endcase
    end
  end

  // State and counter registers. The reset is asynchronous, so every output
  // goes to zero as soon as rst rises, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      retryCnt_q  <= '0;
      victimIdx_q <= '0;
      rejectCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      retryCnt_q  <= retryCnt_d;
      victimIdx_q <= victimIdx_d;
      rejectCnt_q <= rejectCnt_d;
    end
  end

  // Every output is taken from a register, so the victim cannot glitch while
  // it is held for the fill.
  always_comb begin
    victim_vld_o = (state_q == HOLD);
    busy_o       = (state_q != IDLE);
    victim_idx_o = victimIdx_q;
    reject_cnt_o = rejectCnt_q;
  end

  // The decoder is enabled only in HOLD, so the one-hot way is all zeros
  // whenever the victim is not valid.
  ifu_way_onehot_dec #(
    .NUM_WAYS (NUM_WAYS)
  ) u_way_dec (
    .idx_i (victimIdx_q),
    .en_i  (victim_vld_o),
    .way_o (victim_way_o)
  );

  // The requester must keep the miss raised while a draw is in progress.
  // If it drops the miss, the draw still completes, but the drop is flagged.
  missHeldInDraw : assert property (
    @(posedge clk) disable iff (rst)
      ((state_q == DRAW) && !flush_i) |-> miss_req_i
  );

  // The held victim must always name exactly one way.
  victimOneHot : assert property (
    @(posedge clk) disable iff (rst)
      victim_vld_o |-> $onehot(victim_way_o)
  );

endmodule : ifu_rand_victim_sel

// File: tb/tb_ifu_rand_victim_sel.sv
// ----------------------------------------------------------------------------
// tb_ifu_rand_victim_sel
//
// Three selector instances share the stimulus. Only the instance under test
// sees miss_req_i, so the others stay idle.
//   dutA : NUM_WAYS=4, INVALID_FIRST=0 (power of two, no rejections)
//   dutB : NUM_WAYS=3, MAX_RETRY=2     (rejection sampling and fallback)
//   dutC : NUM_WAYS=4, INVALID_FIRST=1 (invalid-way priority)
//
// Each vector is one clock cycle. Its inputs are driven at the falling edge,
// and its expected outputs are those seen 1 ns after the next rising edge.
// ----------------------------------------------------------------------------
module tb_ifu_rand_victim_sel;

  typedef struct {
    string      name;
    int         sel;
    logic [2:0] rnd;
    logic       miss;
    logic [3:0] wayValid;
    logic       fill;
    logic       flush;
    logic       expVld;
    logic [1:0] expIdx;
    logic [3:0] expWay;
    logic       expBusy;
    logic [15:0] expRej;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rnd;
  logic [3:0] wayValid;
  logic       fillDone;
  logic       flush;
  logic       missA, missB, missC;

  logic        vldA, vldB, vldC;
  logic [3:0]  wayA, wayC;
  logic [2:0]  wayB;
  logic [1:0]  idxA, idxB, idxC;
  logic        busyA, busyB, busyC;
  logic [15:0] rejA, rejB, rejC;

  always #5 clk = ~clk;

  ifu_rand_victim_sel #(.NUM_WAYS(4), .RND_W(3), .MAX_RETRY(7), .INVALID_FIRST(0)) dutA (
    .clk(clk), .rst(rst), .rnd_i(rnd), .miss_req_i(missA), .way_valid_i(wayValid),
    .fill_done_i(fillDone), .flush_i(flush), .victim_vld_o(vldA), .victim_way_o(wayA),
    .victim_idx_o(idxA), .busy_o(busyA), .reject_cnt_o(rejA)
  );

  ifu_rand_victim_sel #(.NUM_WAYS(3), .RND_W(3), .MAX_RETRY(2), .INVALID_FIRST(0)) dutB (
    .clk(clk), .rst(rst), .rnd_i(rnd), .miss_req_i(missB), .way_valid_i(wayValid[2:0]),
    .fill_done_i(fillDone), .flush_i(flush), .victim_vld_o(vldB), .victim_way_o(wayB),
    .victim_idx_o(idxB), .busy_o(busyB), .reject_cnt_o(rejB)
  );

  ifu_rand_victim_sel #(.NUM_WAYS(4), .RND_W(3), .MAX_RETRY(7), .INVALID_FIRST(1)) dutC (
    .clk(clk), .rst(rst), .rnd_i(rnd), .miss_req_i(missC), .way_valid_i(wayValid),
    .fill_done_i(fillDone), .flush_i(flush), .victim_vld_o(vldC), .victim_way_o(wayC),
    .victim_idx_o(idxC), .busy_o(busyC), .reject_cnt_o(rejC)
  );

  // Appends one cycle of stimulus and its expected outputs to the table.
  function automatic void addVec(string name, int sel, logic [2:0] r, logic m,
                                 logic [3:0] wv, logic fd, logic fl, logic eVld,
                                 logic [1:0] eIdx, logic [3:0] eWay, logic eBusy,
                                 logic [15:0] eRej);
    vec_t v;
    v.name = name; v.sel = sel; v.rnd = r; v.miss = m; v.wayValid = wv;
    v.fill = fd; v.flush = fl; v.expVld = eVld; v.expIdx = eIdx;
    v.expWay = eWay; v.expBusy = eBusy; v.expRej = eRej;
    vecs.push_back(v);
  endfunction

  // Drives the shared inputs and raises the miss only on the selected DUT.
  task automatic applyStimulus(input vec_t v);
    rnd      = v.rnd;
    wayValid = v.wayValid;
    fillDone = v.fill;
    flush    = v.flush;
    missA    = (v.sel == 0) ? v.miss : 1'b0;
    missB    = (v.sel == 1) ? v.miss : 1'b0;
    missC    = (v.sel == 2) ? v.miss : 1'b0;
  endtask

  // Compares one observed value against its expected value and records
  // the result.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Collects the outputs of the selected DUT into one common format.
  task automatic getOutputs(input int sel, output logic vld, output logic [1:0] idx,
                            output logic [3:0] way, output logic busy,
                            output logic [15:0] rej);
    case (sel)
      0:       begin vld = vldA; idx = idxA; way = wayA;         busy = busyA; rej = rejA; end
      1:       begin vld = vldB; idx = idxB; way = {1'b0, wayB}; busy = busyB; rej = rejB; end
      default: begin vld = vldC; idx = idxC; way = wayC;         busy = busyC; rej = rejC; end
    endcase
  endtask

  // Checks every output of one DUT against the given expected values.
  task automatic checkAll(input string tag, input int sel, input logic eVld,
                          input logic [1:0] eIdx, input logic [3:0] eWay,
                          input logic eBusy, input logic [15:0] eRej);
    logic vld, busy;
    logic [1:0] idx;
    logic [3:0] way;
    logic [15:0] rej;
    getOutputs(sel, vld, idx, way, busy, rej);
    checkOutput({tag, ".vld"},  {31'd0, vld},  {31'd0, eVld});
    checkOutput({tag, ".idx"},  {30'd0, idx},  {30'd0, eIdx});
    checkOutput({tag, ".way"},  {28'd0, way},  {28'd0, eWay});
    checkOutput({tag, ".busy"}, {31'd0, busy}, {31'd0, eBusy});
    checkOutput({tag, ".rej"},  {16'd0, rej},  {16'd0, eRej});
  endtask

  // Safety net in case the run never reaches its own end.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // dutA: power-of-two way count, so a draw is always accepted.
    addVec("a_miss",      0, 3'd0, 1, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd0);
    addVec("a_acc2",      0, 3'd6, 1, 4'hF, 0, 0, 1, 2'd2, 4'b0100, 1, 16'd0);
    addVec("a_holdStable",0, 3'd1, 0, 4'hF, 0, 0, 1, 2'd2, 4'b0100, 1, 16'd0);
    addVec("a_fill",      0, 3'd0, 0, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 0, 16'd0);
    addVec("a_miss2",     0, 3'd0, 1, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd0);
    addVec("a_acc3",      0, 3'd7, 1, 4'hF, 0, 0, 1, 2'd3, 4'b1000, 1, 16'd0);
    addVec("a_fill2",     0, 3'd0, 0, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 0, 16'd0);
    addVec("a_miss3",     0, 3'd0, 1, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd0);
    addVec("a_acc1",      0, 3'd5, 1, 4'hF, 0, 0, 1, 2'd1, 4'b0010, 1, 16'd0);
    addVec("a_fillMiss",  0, 3'd0, 1, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 0, 16'd0);
    addVec("a_redraw",    0, 3'd0, 1, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd0);
    addVec("a_flushDraw", 0, 3'd2, 1, 4'hF, 0, 1, 0, 2'd0, 4'b0000, 0, 16'd0);
    addVec("a_idle",      0, 3'd0, 0, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 0, 16'd0);
    addVec("a_miss4",     0, 3'd0, 1, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd0);
    addVec("a_acc0",      0, 3'd0, 1, 4'hF, 0, 0, 1, 2'd0, 4'b0001, 1, 16'd0);
    addVec("a_flushHold", 0, 3'd0, 0, 4'hF, 0, 1, 0, 2'd0, 4'b0000, 0, 16'd0);
    addVec("a_fillIdle",  0, 3'd0, 0, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 0, 16'd0);
    addVec("a_missFill",  0, 3'd0, 1, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 1, 16'd0);
    addVec("a_fillDraw",  0, 3'd3, 1, 4'hF, 1, 0, 1, 2'd3, 4'b1000, 1, 16'd0);
    addVec("a_fill3",     0, 3'd0, 0, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 0, 16'd0);
    // dutB: three ways. Low bits of 3 are rejected; the reject count is cumulative.
    addVec("b_miss",      1, 3'd0, 1, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd0);
    addVec("b_rej1",      1, 3'd3, 1, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd1);
    addVec("b_rej2",      1, 3'd7, 1, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd2);
    addVec("b_acc1",      1, 3'd1, 1, 4'hF, 0, 0, 1, 2'd1, 4'b0010, 1, 16'd2);
    addVec("b_fill",      1, 3'd0, 0, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 0, 16'd2);
    addVec("b_miss2",     1, 3'd0, 1, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd2);
    addVec("b_rejA",      1, 3'd3, 1, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd3);
    addVec("b_rejB",      1, 3'd3, 1, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd4);
    addVec("b_fallback",  1, 3'd3, 1, 4'hF, 0, 0, 1, 2'd0, 4'b0001, 1, 16'd5);
    addVec("b_fill2",     1, 3'd0, 0, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 0, 16'd5);
    addVec("b_miss3",     1, 3'd0, 1, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd5);
    addVec("b_acc2",      1, 3'd6, 1, 4'hF, 0, 0, 1, 2'd2, 4'b0100, 1, 16'd5);
    addVec("b_fill3",     1, 3'd0, 0, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 0, 16'd5);
    // dutC: the lowest invalid way wins over the random draw.
    addVec("c_miss",      2, 3'd0, 1, 4'b1011, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd0);
    addVec("c_inv2",      2, 3'd1, 1, 4'b1011, 0, 0, 1, 2'd2, 4'b0100, 1, 16'd0);
    addVec("c_fill",      2, 3'd0, 0, 4'b1011, 1, 0, 0, 2'd0, 4'b0000, 0, 16'd0);
    addVec("c_miss2",     2, 3'd0, 1, 4'b1111, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd0);
    addVec("c_rand3",     2, 3'd7, 1, 4'b1111, 0, 0, 1, 2'd3, 4'b1000, 1, 16'd0);
    addVec("c_fill2",     2, 3'd0, 0, 4'b1111, 1, 0, 0, 2'd0, 4'b0000, 0, 16'd0);
    addVec("c_miss3",     2, 3'd0, 1, 4'b0110, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd0);
    addVec("c_inv0",      2, 3'd6, 1, 4'b0110, 0, 0, 1, 2'd0, 4'b0001, 1, 16'd0);
    addVec("c_fill3",     2, 3'd0, 0, 4'b0110, 1, 0, 0, 2'd0, 4'b0000, 0, 16'd0);
    addVec("c_miss4",     2, 3'd0, 1, 4'b0111, 0, 0, 0, 2'd0, 4'b0000, 1, 16'd0);
    addVec("c_inv3",      2, 3'd0, 1, 4'b0111, 0, 0, 1, 2'd3, 4'b1000, 1, 16'd0);
    addVec("c_fill4",     2, 3'd0, 0, 4'b0111, 1, 0, 0, 2'd0, 4'b0000, 0, 16'd0);

    rst = 1'b1; rnd = '0; wayValid = 4'hF; fillDone = 0; flush = 0;
    missA = 0; missB = 0; missC = 0;
    #12;
    checkAll("resetA", 0, 0, 2'd0, 4'b0000, 0, 16'd0);
    checkAll("resetB", 1, 0, 2'd0, 4'b0000, 0, 16'd0);
    checkAll("resetC", 2, 0, 2'd0, 4'b0000, 0, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkAll(vecs[i].name, vecs[i].sel, vecs[i].expVld, vecs[i].expIdx,
               vecs[i].expWay, vecs[i].expBusy, vecs[i].expRej);
    end

    // Async reset in the middle of a HOLD, then a fresh miss at minimum latency.
    @(negedge clk); rnd = 3'd0; missA = 1; fillDone = 0; flush = 0; wayValid = 4'hF;
    @(posedge clk); #1;
    @(negedge clk); rnd = 3'd6;
    @(posedge clk); #1;
    checkAll("rstHoldPre", 0, 1, 2'd2, 4'b0100, 1, 16'd0);
    #2;
    missA = 0;
    rst = 1'b1;
    #1;
    checkAll("rstAsyncA", 0, 0, 2'd0, 4'b0000, 0, 16'd0);
    checkAll("rstAsyncB", 1, 0, 2'd0, 4'b0000, 0, 16'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rnd = 3'd0; missA = 1;
    @(posedge clk); #1;
    checkAll("postRstDraw", 0, 0, 2'd0, 4'b0000, 1, 16'd0);
    @(negedge clk); rnd = 3'd5;
    @(posedge clk); #1;
    checkAll("postRstHold", 0, 1, 2'd1, 4'b0010, 1, 16'd0);
    @(negedge clk); missA = 0; fillDone = 1;
    @(posedge clk); #1;
    checkAll("postRstFill", 0, 0, 2'd0, 4'b0000, 0, 16'd0);
    @(negedge clk); fillDone = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ifu_rand_victim_sel

// File: doc/ifu_rand_victim_sel.md
Name: ifu_rand_victim_sel

Overview:
Random-replacement victim selector for the MBPTA I-cache.
- Consumes the per-cycle pseudo-random value from the IFU LFSR PRNG and turns it into a uniformly distributed victim way on each I-cache miss.
- Uses rejection sampling when NUM_WAYS is not a power of two.
- Holds the chosen way stable until the fill completes.
- Sits between the PRNG and the I-cache fill/tag-write logic in the IFU.

Parameters:
NUM_WAYS, 4, number of I-cache ways (2..8)
IDX_W, $clog2(NUM_WAYS), way-index width (derived, not overridable)
RND_W, 3, width of rnd_i; must be >= IDX_W
MAX_RETRY, 7, rejected draws allowed before deterministic fallback (1..15)
INVALID_FIRST, 0, 1 = fill the lowest-index invalid way before drawing randomly

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
rnd_i  input  RND_W  PRNG output; new value every cycle
miss_req_i  input  1  level request; held by the requester until victim_vld_o
way_valid_i  input  NUM_WAYS  valid bits of the missed set; stable while miss_req_i is high
fill_done_i  input  1  single-cycle pulse; fill written, victim released
flush_i  input  1  abort any selection in progress
victim_vld_o  output  1  victim_way_o/victim_idx_o valid and stable
victim_way_o  output  NUM_WAYS  one-hot victim way
victim_idx_o  output  IDX_W  binary victim way
busy_o  output  1  state != IDLE
reject_cnt_o  output  16  saturating count of rejected draws since reset

Behaviour:
Reset (async, rst=1):
- state=IDLE; retry_cnt=0; victim regs=0; reject_cnt_o=0.
- All outputs 0.

State machine (IDLE, DRAW, HOLD):
- IDLE: miss_req_i=1 -> DRAW.
- DRAW, evaluated each cycle, in priority order:
  - (a) INVALID_FIRST=1 and any way_valid_i bit is 0: victim = lowest-index invalid way -> HOLD.
  - (b) cand = rnd_i[IDX_W-1:0] < NUM_WAYS: victim = cand -> HOLD.
  - (c) Otherwise reject: reject_cnt_o++ (saturates at 16'hFFFF); retry_cnt++; stay in DRAW.
  - (d) When a rejection occurs with retry_cnt == MAX_RETRY: victim = cand - NUM_WAYS (always in range, since cand < 2*NUM_WAYS) -> HOLD. This draw still counts as a rejection.
- HOLD:
  - victim_vld_o=1; victim outputs are registered and must not change.
  - fill_done_i=1 -> IDLE; retry_cnt cleared.
- retry_cnt is cleared on entry to DRAW.

Latency:
- miss_req_i first seen high in IDLE at cycle N -> DRAW at N+1.
- Accepted draw -> victim_vld_o=1 at N+2 (minimum).
- Worst case: N+2+MAX_RETRY.

Boundary conditions:
- Power-of-two NUM_WAYS: rejection is impossible; reject_cnt_o stays 0.
- flush_i has priority over every other event in every state: -> IDLE next cycle; victim_vld_o=0 next cycle; victim regs cleared.
- fill_done_i outside HOLD is ignored.
- fill_done_i and miss_req_i both high in HOLD: -> IDLE. The new miss enters DRAW one cycle later, so there are no back-to-back HOLDs without an IDLE cycle.
- miss_req_i dropping while in DRAW: protocol violation; an assertion flags it. The RTL completes the draw anyway.
- victim_way_o is always one-hot when victim_vld_o=1 and all-zero otherwise.

Decomposition:
- Shared package: victim_sel_state_e enum (IDLE, DRAW, HOLD) and the REJECT_CNT_W=16 constant.
- Sub-module ifu_way_onehot_dec (IDX_W -> NUM_WAYS binary-to-one-hot), reused by the fill path.
- Lowest-invalid priority encoder stays inline.

Test Plan:
1. NUM_WAYS=4, rnd_i=3'b110, miss_req at cycle 0 -> victim_vld_o=1 at cycle 2, victim_idx_o=2, victim_way_o=4'b0100, reject_cnt_o=0.
2. NUM_WAYS=3, rnd_i[1:0] sequence 3,3,1 -> two rejects, victim_idx_o=1 at cycle 4, reject_cnt_o=2.
3. NUM_WAYS=3, MAX_RETRY=2, rnd_i[1:0] held at 3 -> fallback victim_idx_o=0 at cycle 4, reject_cnt_o=3.
4. INVALID_FIRST=1, way_valid_i=4'b1011, any rnd_i -> victim_idx_o=2 at cycle 2, no random draw used.
5. In HOLD pulse fill_done_i -> busy_o=0 next cycle; miss_req_i held high -> DRAW the cycle after; then flush_i in DRAW -> IDLE, victim_vld_o stays 0.
6. Assert rst mid-HOLD (async, between clock edges) -> all outputs 0 immediately; reject_cnt_o=0; first miss after release follows the cycle-2 latency.
